axi4_lite_master_engine: RTL and testbench

- Synthesizable AXI4-Lite initiator that converts single-beat commands from a local valid/ready command port into AXI4-Lite write or read transactions.
- Returns one response per command on a valid/ready response port.
- Sits in front of the team's AXI4-Lite register slave so that RTL, rather than a VIP, can drive register traffic in-system (config sequencers, self-test).
- Exactly one transaction outstanding at a time.

---
 rtl/axi4_lite_master_engine.sv | 213 +++++++++++++++++++++
 tb/tb_axi4_lite_master_engine.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_master_engine.sv
// Single-outstanding AXI4-Lite initiator: one local command in, one AXI transaction, one response out.
// Define AXIL_MST_ADDR_CHECK_EN to reject unaligned or out-of-window addresses locally with DECERR.
`default_nettype none

module axi4_lite_master_engine #(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = {ADDR_WIDTH{1'b0}},
   parameter int                    REGISTERS  = 16
) (
   input  logic                      aclk,
   input  logic                      aresetn,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic                      cmd_write,
   input  logic [ADDR_WIDTH-1:0]     cmd_addr,
   input  logic [DATA_WIDTH-1:0]     cmd_wdata,
   input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic                      rsp_write,
   output logic [DATA_WIDTH-1:0]     rsp_rdata,
   output logic [1:0]                rsp_resp,
   output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
   output logic [2:0]                m_axi_awprot,
   output logic                      m_axi_awvalid,
   input  logic                      m_axi_awready,
   output logic [DATA_WIDTH-1:0]     m_axi_wdata,
   output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
   output logic                      m_axi_wvalid,
   input  logic                      m_axi_wready,
   input  logic [1:0]                m_axi_bresp,
   input  logic                      m_axi_bvalid,
   output logic                      m_axi_bready,
   output logic [ADDR_WIDTH-1:0]     m_axi_araddr,
   output logic [2:0]                m_axi_arprot,
   output logic                      m_axi_arvalid,
   input  logic                      m_axi_arready,
   input  logic [DATA_WIDTH-1:0]     m_axi_rdata,
   input  logic [1:0]                m_axi_rresp,
   input  logic                      m_axi_rvalid,
   output logic                      m_axi_rready
);

   localparam int STRB_W  = DATA_WIDTH / 8;
   localparam int ALIGN_W = $clog2(STRB_W);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_WRITE = 3'd1;
   localparam logic [2:0] S_WRESP = 3'd2;
   localparam logic [2:0] S_RADDR = 3'd3;
   localparam logic [2:0] S_RDATA = 3'd4;
   localparam logic [2:0] S_RESP  = 3'd5;

`ifdef AXIL_MST_ADDR_CHECK_EN
   localparam logic CHECK_EN = 1'b1;
`else
   localparam logic CHECK_EN = 1'b0;
`endif

   logic [2:0]              r_state;
   logic                    r_cmd_ready;
   logic                    r_awvalid;
   logic                    r_wvalid;
   logic                    r_bready;
   logic                    r_arvalid;
   logic                    r_rready;
   logic                    r_rsp_valid;
   logic                    r_write;
   logic [ADDR_WIDTH-1:0]   r_addr;
   logic [DATA_WIDTH-1:0]   r_wdata;
   logic [STRB_W-1:0]       r_wstrb;
   logic [DATA_WIDTH-1:0]   r_rsp_rdata;
   logic [1:0]              r_rsp_resp;

   logic [ADDR_WIDTH:0]     w_offset;
   logic                    w_unaligned;
   logic                    w_out_of_window;
   logic                    w_addr_bad;
   logic                    w_aw_done;
   logic                    w_w_done;

   // Offset wraps to a huge value below BASE_ADDR, so one compare covers both window edges
   assign w_offset        = {1'b0, cmd_addr} - {1'b0, BASE_ADDR};
   assign w_unaligned     = |cmd_addr[ALIGN_W-1:0];
   assign w_out_of_window = w_offset >= (ADDR_WIDTH+1)'(REGISTERS * STRB_W);
   assign w_addr_bad      = CHECK_EN & (w_unaligned | w_out_of_window);

   assign w_aw_done = ~r_awvalid | m_axi_awready;
   assign w_w_done  = ~r_wvalid  | m_axi_wready;

   // Command capture, AXI channel sequencing and response holding
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state     <= S_IDLE;
         r_cmd_ready <= 1'b0;
         r_awvalid   <= 1'b0;
         r_wvalid    <= 1'b0;
         r_bready    <= 1'b0;
         r_arvalid   <= 1'b0;
         r_rready    <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_write     <= 1'b0;
         r_addr      <= {ADDR_WIDTH{1'b0}};
         r_wdata     <= {DATA_WIDTH{1'b0}};
         r_wstrb     <= {STRB_W{1'b0}};
         r_rsp_rdata <= {DATA_WIDTH{1'b0}};
         r_rsp_resp  <= 2'b00;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (cmd_valid && r_cmd_ready) begin
                  r_cmd_ready <= 1'b0;
                  r_write     <= cmd_write;
                  r_addr      <= cmd_addr;
                  r_wdata     <= cmd_wdata;
                  r_wstrb     <= cmd_wstrb;
                  if (w_addr_bad) begin
                     r_rsp_resp  <= 2'b11;
                     r_rsp_rdata <= {DATA_WIDTH{1'b0}};
                     r_rsp_valid <= 1'b1;
                     r_state     <= S_RESP;
                  end else if (cmd_write) begin
                     r_awvalid <= 1'b1;
                     r_wvalid  <= 1'b1;
                     r_state   <= S_WRITE;
                  end else begin
                     r_arvalid <= 1'b1;
                     r_state   <= S_RADDR;
                  end
               end else begin
                  r_cmd_ready <= 1'b1;
               end
            end
            S_WRITE: begin
               if (r_awvalid && m_axi_awready) begin
                  r_awvalid <= 1'b0;
               end
               if (r_wvalid && m_axi_wready) begin
                  r_wvalid <= 1'b0;
               end
               if (w_aw_done && w_w_done) begin
                  r_bready <= 1'b1;
                  r_state  <= S_WRESP;
               end
            end
            S_WRESP: begin
               if (m_axi_bvalid) begin
                  r_bready    <= 1'b0;
                  r_rsp_resp  <= m_axi_bresp;
                  r_rsp_rdata <= {DATA_WIDTH{1'b0}};
                  r_rsp_valid <= 1'b1;
                  r_state     <= S_RESP;
               end
            end
            S_RADDR: begin
               if (m_axi_arready) begin
                  r_arvalid <= 1'b0;
                  r_rready  <= 1'b1;
                  r_state   <= S_RDATA;
               end
            end
            S_RDATA: begin
               if (m_axi_rvalid) begin
                  r_rready    <= 1'b0;
                  r_rsp_rdata <= m_axi_rdata;
                  r_rsp_resp  <= m_axi_rresp;
                  r_rsp_valid <= 1'b1;
                  r_state     <= S_RESP;
               end
            end
            S_RESP: begin
               // Raising cmd_ready here lets a new command land on the very next cycle
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_cmd_ready <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_cmd_ready <= 1'b0;
               r_awvalid   <= 1'b0;
               r_wvalid    <= 1'b0;
               r_bready    <= 1'b0;
               r_arvalid   <= 1'b0;
               r_rready    <= 1'b0;
               r_rsp_valid <= 1'b0;
            end
         endcase
      end
   end

   assign cmd_ready     = r_cmd_ready;
   assign rsp_valid     = r_rsp_valid;
   assign rsp_write     = r_write;
   assign rsp_rdata     = r_rsp_rdata;
   assign rsp_resp      = r_rsp_resp;
   assign m_axi_awaddr  = r_addr;
   assign m_axi_awprot  = 3'b000;
   assign m_axi_awvalid = r_awvalid;
   assign m_axi_wdata   = r_wdata;
   assign m_axi_wstrb   = r_wstrb;
   assign m_axi_wvalid  = r_wvalid;
   assign m_axi_bready  = r_bready;
   assign m_axi_araddr  = r_addr;
   assign m_axi_arprot  = 3'b000;
   assign m_axi_arvalid = r_arvalid;
   assign m_axi_rready  = r_rready;

endmodule

`default_nettype wire

// File: tb/tb_axi4_lite_master_engine.sv
// Scoreboard bench for axi4_lite_master_engine with a small reactive AXI4-Lite slave model.
// Build with AXIL_MST_ADDR_CHECK_EN defined to exercise the address-window rejection path.
`timescale 1ns/1ps

module tb_axi4_lite_master_engine;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = DW / 8;

   typedef struct packed {
      logic          w;
      logic [DW-1:0] d;
      logic [1:0]    r;
   } rsp_t;

   logic          aclk = 1'b0;
   logic          aresetn;
   logic          cmd_valid, cmd_ready, cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic [SW-1:0] cmd_wstrb;
   logic          rsp_valid, rsp_ready, rsp_write;
   logic [DW-1:0] rsp_rdata;
   logic [1:0]    rsp_resp;
   logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
   logic [2:0]    m_axi_awprot, m_axi_arprot;
   logic          m_axi_awvalid, m_axi_awready;
   logic [DW-1:0] m_axi_wdata, m_axi_rdata;
   logic [SW-1:0] m_axi_wstrb;
   logic          m_axi_wvalid, m_axi_wready;
   logic [1:0]    m_axi_bresp, m_axi_rresp;
   logic          m_axi_bvalid, m_axi_bready;
   logic          m_axi_arvalid, m_axi_arready;
   logic          m_axi_rvalid, m_axi_rready;

   always #5 aclk = ~aclk;

   axi4_lite_master_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BASE_ADDR(32'h0), .REGISTERS(16)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
      .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
      .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
      .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
      .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
      .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
      .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
      .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
      .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
      .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
   );

   // ---------------- slave model ----------------
   logic [DW-1:0] mem [0:63];
   logic          s_aw_got = 1'b0, s_w_got = 1'b0;
   logic [AW-1:0] s_awaddr;
   logic [DW-1:0] s_wdata;
   logic [SW-1:0] s_wstrb;
   logic          bhold, force_r;
   logic [DW-1:0] force_rdata;
   logic [1:0]    force_rresp;
   int            aw_hs_cnt = 0, w_hs_cnt = 0, ar_hs_cnt = 0;
   logic [AW-1:0] last_awaddr;
   logic [DW-1:0] last_wdata;

   logic          c_aw_hs, c_w_hs, c_ag, c_wg;
   logic [AW-1:0] c_a;
   logic [DW-1:0] c_d;
   logic [SW-1:0] c_s;
   assign c_aw_hs = m_axi_awvalid && m_axi_awready;
   assign c_w_hs  = m_axi_wvalid && m_axi_wready;
   assign c_ag    = s_aw_got | c_aw_hs;
   assign c_wg    = s_w_got | c_w_hs;
   assign c_a     = c_aw_hs ? m_axi_awaddr : s_awaddr;
   assign c_d     = c_w_hs ? m_axi_wdata : s_wdata;
   assign c_s     = c_w_hs ? m_axi_wstrb : s_wstrb;

   always @(posedge aclk) begin
      if (!aresetn) begin
         s_aw_got     <= 1'b0;
         s_w_got      <= 1'b0;
         m_axi_bvalid <= 1'b0;
         m_axi_rvalid <= 1'b0;
      end else begin
         if (c_aw_hs) begin
            aw_hs_cnt   <= aw_hs_cnt + 1;
            last_awaddr <= m_axi_awaddr;
         end
         if (c_w_hs) begin
            w_hs_cnt   <= w_hs_cnt + 1;
            last_wdata <= m_axi_wdata;
         end
         if (m_axi_bvalid && m_axi_bready) m_axi_bvalid <= 1'b0;
         if (c_ag && c_wg && !bhold && !m_axi_bvalid) begin
            for (int b = 0; b < SW; b++)
               if (c_s[b]) mem[c_a[7:2]][8*b +: 8] <= c_d[8*b +: 8];
            m_axi_bvalid <= 1'b1;
            m_axi_bresp  <= 2'b00;
            s_aw_got     <= 1'b0;
            s_w_got      <= 1'b0;
         end else begin
            s_aw_got <= c_ag;
            s_w_got  <= c_wg;
            s_awaddr <= c_a;
            s_wdata  <= c_d;
            s_wstrb  <= c_s;
         end
         if (m_axi_rvalid && m_axi_rready) m_axi_rvalid <= 1'b0;
         if (m_axi_arvalid && m_axi_arready && !m_axi_rvalid) begin
            ar_hs_cnt    <= ar_hs_cnt + 1;
            m_axi_rvalid <= 1'b1;
            m_axi_rdata  <= force_r ? force_rdata : mem[m_axi_araddr[7:2]];
            m_axi_rresp  <= force_r ? force_rresp : 2'b00;
         end
      end
   end

   // ---------------- scoreboard ----------------
   rsp_t sb_q[$];
   int   n_cmp = 0, n_err = 0, rsp_cnt = 0;

   always @(negedge aclk) begin : monitor
      rsp_t e;
      if (aresetn && rsp_valid && rsp_ready) begin
         rsp_cnt = rsp_cnt + 1;
         n_cmp   = n_cmp + 1;
         if (sb_q.size() == 0) begin
            n_err = n_err + 1;
            $display("FAIL rsp_unexpected: got w=%0b d=%h r=%0d, expected no response", rsp_write, rsp_rdata, rsp_resp);
         end else begin
            e = sb_q.pop_front();
            if ({rsp_write, rsp_rdata, rsp_resp} !== e) begin
               n_err = n_err + 1;
               $display("FAIL rsp_scoreboard: got w=%0b d=%h r=%0d, expected w=%0b d=%h r=%0d",
                        rsp_write, rsp_rdata, rsp_resp, e.w, e.d, e.r);
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1, "watchdog expired");
   end

   // ---------------- helpers ----------------
   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic send_cmd(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [SW-1:0] s, input rsp_t exp, input logic push);
      tick();
      cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
      for (int n = 0; n < 200; n++) begin
         @(negedge aclk);
         if (cmd_ready) begin
            if (push) sb_q.push_back(exp);
            tick();
            cmd_valid = 1'b0;
            return;
         end
      end
      cmd_valid = 1'b0;
      n_cmp = n_cmp + 1; n_err = n_err + 1;
      $display("FAIL cmd_timeout: cmd_ready=0 after 200 cycles, expected 1 (addr %h)", a);
   endtask

   task automatic wait_rsp(output int lat);
      lat = -1;
      for (int k = 1; k <= 200; k++) begin
         @(negedge aclk);
         if (rsp_valid) begin
            lat = k;
            return;
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      @(negedge aclk);
      n_cmp = n_cmp + 1;
      if ({cmd_ready, rsp_valid, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready} !== 7'b0) begin
         n_err = n_err + 1;
         $display("FAIL reset_valids: got %b, expected 0000000", {cmd_ready, rsp_valid, m_axi_awvalid,
                  m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready});
      end
      n_cmp = n_cmp + 1;
      if ({m_axi_awaddr, m_axi_wdata, m_axi_wstrb, rsp_rdata, rsp_resp} !== '0) begin
         n_err = n_err + 1;
         $display("FAIL reset_regs: got awaddr=%h wdata=%h rdata=%h resp=%0d, expected all 0",
                  m_axi_awaddr, m_axi_wdata, rsp_rdata, rsp_resp);
      end
      #1 aresetn = 1'b1;
      #1;
      n_cmp = n_cmp + 1;
      if (cmd_ready !== 1'b0) begin
         n_err = n_err + 1;
         $display("FAIL release_no_edge: cmd_ready=%b, expected 0", cmd_ready);
      end
      @(negedge aclk);
      n_cmp = n_cmp + 1;
      if (cmd_ready !== 1'b1) begin
         n_err = n_err + 1;
         $display("FAIL release_first_edge: cmd_ready=%b, expected 1", cmd_ready);
      end
   endtask

   task automatic test_single_write();
      int lat, aw0, w0, rc0;
      aw0 = aw_hs_cnt; w0 = w_hs_cnt; rc0 = rsp_cnt;
      send_cmd(1'b1, 32'h8, 32'hDEADBEEF, 4'hF, {1'b1, 32'h0, 2'b00}, 1'b1);
      wait_rsp(lat);
      n_cmp = n_cmp + 1;
      if (lat !== 3) begin
         n_err = n_err + 1;
         $display("FAIL write_latency: got %0d cycles, expected 3", lat);
      end
      tick();
      @(negedge aclk);
      n_cmp = n_cmp + 1;
      if (aw_hs_cnt - aw0 !== 1 || w_hs_cnt - w0 !== 1 || last_awaddr !== 32'h8 || last_wdata !== 32'hDEADBEEF) begin
         n_err = n_err + 1;
         $display("FAIL write_bus: got aw=%0d w=%0d awaddr=%h wdata=%h, expected 1 1 00000008 deadbeef",
                  aw_hs_cnt - aw0, w_hs_cnt - w0, last_awaddr, last_wdata);
      end
      n_cmp = n_cmp + 1;
      if (rsp_cnt - rc0 !== 1) begin
         n_err = n_err + 1;
         $display("FAIL write_rsp_count: got %0d, expected 1", rsp_cnt - rc0);
      end
   endtask

   task automatic test_loop();
      int lat, rc0;
      rc0 = rsp_cnt;
      for (int i = 0; i < 16; i++) begin
         send_cmd(1'b1, 32'(4*i), 32'(i), 4'hF, {1'b1, 32'h0, 2'b00}, 1'b1);
         wait_rsp(lat);
         send_cmd(1'b0, 32'(4*i), 32'h0, 4'h0, {1'b0, 32'(i), 2'b00}, 1'b1);
         wait_rsp(lat);
         n_cmp = n_cmp + 1;
         if (lat !== 3) begin
            n_err = n_err + 1;
            $display("FAIL read_latency[%0d]: got %0d cycles, expected 3", i, lat);
         end
      end
      tick();
      @(negedge aclk);
      n_cmp = n_cmp + 1;
      if (rsp_cnt - rc0 !== 32) begin
         n_err = n_err + 1;
         $display("FAIL loop_rsp_count: got %0d, expected 32", rsp_cnt - rc0);
      end
   endtask

   task automatic test_aw_stall();
      int lat, aw0, w0, rc0;
      aw0 = aw_hs_cnt; w0 = w_hs_cnt; rc0 = rsp_cnt;
      m_axi_awready = 1'b0;
      send_cmd(1'b1, 32'h10, 32'h55AA55AA, 4'hF, {1'b1, 32'h0, 2'b00}, 1'b1);
      for (int c = 1; c <= 5; c++) begin
         @(negedge aclk);
         n_cmp = n_cmp + 1;
         if (m_axi_awvalid !== 1'b1 || m_axi_awaddr !== 32'h10 || m_axi_wvalid !== (c == 1)) begin
            n_err = n_err + 1;
            $display("FAIL aw_stall[%0d]: got awvalid=%b awaddr=%h wvalid=%b, expected 1 00000010 %0b",
                     c, m_axi_awvalid, m_axi_awaddr, m_axi_wvalid, (c == 1));
         end
      end
      tick();
      m_axi_awready = 1'b1;
      wait_rsp(lat);
      tick();
      @(negedge aclk);
      n_cmp = n_cmp + 1;
      if (lat < 0 || aw_hs_cnt - aw0 !== 1 || w_hs_cnt - w0 !== 1 || rsp_cnt - rc0 !== 1) begin
         n_err = n_err + 1;
         $display("FAIL aw_stall_counts: got lat=%0d aw=%0d w=%0d rsp=%0d, expected lat>=0 1 1 1",
                  lat, aw_hs_cnt - aw0, w_hs_cnt - w0, rsp_cnt - rc0);
      end
   endtask

   task automatic test_read_backpressure();
      int lat;
      force_r = 1'b1; force_rdata = 32'h1234; force_rresp = 2'b10;
      rsp_ready = 1'b0;
      send_cmd(1'b0, 32'h20, 32'h0, 4'h0, {1'b0, 32'h1234, 2'b10}, 1'b1);
      wait_rsp(lat);
      n_cmp = n_cmp + 1;
      if (lat !== 3) begin
         n_err = n_err + 1;
         $display("FAIL bp_latency: got %0d cycles, expected 3", lat);
      end
      for (int j = 0; j < 4; j++) begin
         n_cmp = n_cmp + 1;
         if ({rsp_valid, cmd_ready, rsp_write, rsp_rdata, rsp_resp} !== {1'b1, 1'b0, 1'b0, 32'h1234, 2'b10}) begin
            n_err = n_err + 1;
            $display("FAIL bp_hold[%0d]: got valid=%b cmd_ready=%b w=%b d=%h r=%0d, expected 1 0 0 00001234 2",
                     j, rsp_valid, cmd_ready, rsp_write, rsp_rdata, rsp_resp);
         end
         @(negedge aclk);
      end
      tick();
      rsp_ready = 1'b1;
      @(negedge aclk);
      n_cmp = n_cmp + 1;
      if (cmd_ready !== 1'b0 || rsp_valid !== 1'b1) begin
         n_err = n_err + 1;
         $display("FAIL bp_accept_cycle: got cmd_ready=%b rsp_valid=%b, expected 0 1", cmd_ready, rsp_valid);
      end
      @(negedge aclk);
      n_cmp = n_cmp + 1;
      if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         n_err = n_err + 1;
         $display("FAIL bp_after_accept: got cmd_ready=%b rsp_valid=%b, expected 1 0", cmd_ready, rsp_valid);
      end
      force_r = 1'b0;
   endtask

   task automatic test_reset_in_wresp();
      int lat;
      bit seen;
      bhold = 1'b1;
      send_cmd(1'b1, 32'h4, 32'h7, 4'hF, {1'b1, 32'h0, 2'b00}, 1'b0);
      seen = 1'b0;
      for (int n = 0; n < 20 && !seen; n++) begin
         @(negedge aclk);
         if (m_axi_bready) seen = 1'b1;
      end
      n_cmp = n_cmp + 1;
      if (!seen) begin
         n_err = n_err + 1;
         $display("FAIL wresp_reach: bready=0 after 20 cycles, expected 1");
      end
      #2 aresetn = 1'b0;
      #1;
      n_cmp = n_cmp + 1;
      if ({cmd_ready, rsp_valid, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready} !== 7'b0) begin
         n_err = n_err + 1;
         $display("FAIL async_reset: got %b, expected 0000000", {cmd_ready, rsp_valid, m_axi_awvalid,
                  m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready});
      end
      bhold = 1'b0;
      @(negedge aclk);
      @(negedge aclk);
      #1 aresetn = 1'b1;
      send_cmd(1'b0, 32'h30, 32'h0, 4'h0, {1'b0, 32'd12, 2'b00}, 1'b1);
      wait_rsp(lat);
      n_cmp = n_cmp + 1;
      if (lat !== 3) begin
         n_err = n_err + 1;
         $display("FAIL post_reset_read: got latency %0d, expected 3", lat);
      end
   endtask

   task automatic test_addr_window();
      int lat, ar0;
      ar0 = ar_hs_cnt;
`ifdef AXIL_MST_ADDR_CHECK_EN
      send_cmd(1'b0, 32'h40, 32'h0, 4'h0, {1'b0, 32'h0, 2'b11}, 1'b1);
      wait_rsp(lat);
      n_cmp = n_cmp + 1;
      if (lat !== 1) begin
         n_err = n_err + 1;
         $display("FAIL window_above: got latency %0d, expected 1", lat);
      end
      send_cmd(1'b0, 32'h2, 32'h0, 4'h0, {1'b0, 32'h0, 2'b11}, 1'b1);
      wait_rsp(lat);
      n_cmp = n_cmp + 1;
      if (lat !== 1 || ar_hs_cnt !== ar0) begin
         n_err = n_err + 1;
         $display("FAIL window_unaligned: got latency %0d ar=%0d, expected 1 0", lat, ar_hs_cnt - ar0);
      end
      send_cmd(1'b0, 32'h3C, 32'h0, 4'h0, {1'b0, 32'd15, 2'b00}, 1'b1);
      wait_rsp(lat);
`else
      send_cmd(1'b1, 32'h40, 32'hA5, 4'hF, {1'b1, 32'h0, 2'b00}, 1'b1);
      wait_rsp(lat);
      send_cmd(1'b0, 32'h40, 32'h0, 4'h0, {1'b0, 32'hA5, 2'b00}, 1'b1);
      wait_rsp(lat);
`endif
      tick();
      @(negedge aclk);
      n_cmp = n_cmp + 1;
      if (lat !== 3 || ar_hs_cnt - ar0 !== 1) begin
         n_err = n_err + 1;
         $display("FAIL window_bus_read: got latency %0d ar=%0d, expected 3 1", lat, ar_hs_cnt - ar0);
      end
   endtask

   initial begin
      aresetn = 1'b0;
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
      rsp_ready = 1'b1;
      m_axi_awready = 1'b1; m_axi_wready = 1'b1; m_axi_arready = 1'b1;
      bhold = 1'b0; force_r = 1'b0; force_rdata = '0; force_rresp = 2'b00;
      @(negedge aclk);
      test_reset();
      test_single_write();
      test_loop();
      test_aw_stall();
      test_read_backpressure();
      test_reset_in_wresp();
      test_addr_window();
      tick();
      @(negedge aclk);
      n_cmp = n_cmp + 1;
      if (sb_q.size() != 0) begin
         n_err = n_err + 1;
         $display("FAIL sb_leftover: got %0d pending responses, expected 0", sb_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
